// File: rtl/neuron_mv_pkg.sv
// Shared types, mode encodings and the saturation helper for the neuron array.
// The typedefs describe the default build; the modules carry their own
// parameter-sized copies so they stay correct when overridden.
package neuron_mv_pkg;

  localparam int NMV_N_CH  = 4;
  localparam int NMV_W     = 16;
  localparam int NMV_T_REF = 3;
  localparam int NMV_RW    = ($clog2(NMV_T_REF + 1) > 0) ? $clog2(NMV_T_REF + 1) : 1;

  typedef logic signed [NMV_W-1:0]       volt_t;
  typedef logic signed [2*NMV_W+1:0]     wide_t;
  typedef logic        [NMV_RW-1:0]      ref_t;
  typedef logic [$clog2(NMV_N_CH)-1:0]   ch_t;

  localparam logic MODE_LIN  = 1'b0;
  localparam logic MODE_QUAD = 1'b1;

  // Clamp a wide signed value into the range of a signed w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/neuron_array_mv_core.sv
// Combinational single-channel LIF update: refractory hold, leak, optional
// quadratic term, threshold test and saturation. All sums are carried at
// 2W+2 bits so nothing wraps before the final clamp.
module neuron_mv_core
  import neuron_mv_pkg::*;
#(
  parameter int W          = 16,
  parameter int FRAC       = 8,
  parameter int V_REST     = 0,
  parameter int V_TH       = 256,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 4,
  parameter int QSHIFT     = 2,
  parameter int T_REF      = 3,
  parameter int RW         = 2
) (
  input  logic signed [W-1:0]  i_v,
  input  logic        [RW-1:0] i_ref,
  input  logic signed [W-1:0]  i_cur,
  input  logic                 i_mode,
  output logic signed [W-1:0]  o_v,
  output logic        [RW-1:0] o_ref,
  output logic                 o_fire
);

  localparam int WW = 2 * W + 2;
  localparam logic signed [W-1:0] RESET_V = W'(V_RESET);

  logic signed [WW-1:0] w_v;
  logic signed [WW-1:0] w_cur;
  logic signed [WW-1:0] w_d;
  logic signed [WW-1:0] w_leak;
  logic signed [WW-1:0] w_quad;
  logic signed [WW-1:0] w_vnext;

  // Unclamped next membrane value at full width.
  always_comb begin
    w_v    = WW'(i_v);
    w_cur  = WW'(i_cur);
    w_d    = w_v - WW'(V_REST);
    w_leak = w_d >>> LEAK_SHIFT;
    w_quad = '0;
    if (i_mode == MODE_QUAD) w_quad = (w_d * w_d) >>> (FRAC + QSHIFT);
    w_vnext = w_v + w_cur - w_leak + w_quad;
  end

  // Refractory channels ignore current; otherwise fire or store the clamped value.
  always_comb begin
    o_v    = i_v;
    o_ref  = i_ref;
    o_fire = 1'b0;
    if (i_ref != '0) begin
      o_v   = RESET_V;
      o_ref = i_ref - RW'(1);
    end else if (w_vnext >= WW'(V_TH)) begin
      o_fire = 1'b1;
      o_v    = RESET_V;
      o_ref  = RW'(T_REF);
    end else begin
      o_v   = W'(sat_to_w(64'(w_vnext), W));
      o_ref = '0;
    end
  end

endmodule

// File: rtl/neuron_array_mv.sv
// Time-multiplexed array of N_CH LIF neurons sharing one update datapath.
// A round-robin pointer picks one channel per enabled cycle; its result is
// registered together with the spike pulse and the v_out/v_ch report.
module neuron_array_mv
  import neuron_mv_pkg::*;
#(
  parameter int N_CH       = NMV_N_CH,
  parameter int W          = NMV_W,
  parameter int FRAC       = 8,
  parameter int V_REST     = 0,
  parameter int V_TH       = 256,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 4,
  parameter int QSHIFT     = 2,
  parameter int T_REF      = NMV_T_REF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode_sel,
  input  logic [N_CH*W-1:0]         i_in,
  output logic [N_CH-1:0]           spike,
  output logic signed [W-1:0]       v_out,
  output logic [$clog2(N_CH)-1:0]   v_ch,
  output logic                      v_valid
);

  localparam int CW = $clog2(N_CH);
  localparam int RW = ($clog2(T_REF + 1) > 0) ? $clog2(T_REF + 1) : 1;

  logic signed [W-1:0]  r_v   [N_CH];
  logic        [RW-1:0] r_ref [N_CH];
  logic        [CW-1:0] r_ptr;
  logic        [N_CH-1:0] r_spike;
  logic signed [W-1:0]  r_vout;
  logic        [CW-1:0] r_vch;
  logic                 r_vvalid;

  logic signed [W-1:0]  w_cur;
  logic signed [W-1:0]  w_vnew;
  logic        [RW-1:0] w_refnew;
  logic                 w_fire;

  assign w_cur = $signed(i_in[r_ptr*W +: W]);

  neuron_mv_core #(
    .W(W), .FRAC(FRAC), .V_REST(V_REST), .V_TH(V_TH), .V_RESET(V_RESET),
    .LEAK_SHIFT(LEAK_SHIFT), .QSHIFT(QSHIFT), .T_REF(T_REF), .RW(RW)
  ) u_core (
    .i_v   (r_v[r_ptr]),
    .i_ref (r_ref[r_ptr]),
    .i_cur (w_cur),
    .i_mode(mode_sel),
    .o_v   (w_vnew),
    .o_ref (w_refnew),
    .o_fire(w_fire)
  );

  // Commit the selected channel, advance the pointer and register the report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_v[c]   <= W'(V_REST);
        r_ref[c] <= '0;
      end
      r_ptr    <= '0;
      r_spike  <= '0;
      r_vout   <= '0;
      r_vch    <= '0;
      r_vvalid <= 1'b0;
    end else if (en) begin
      r_v[r_ptr]   <= w_vnew;
      r_ref[r_ptr] <= w_refnew;
      r_ptr        <= (r_ptr == CW'(N_CH - 1)) ? '0 : r_ptr + CW'(1);
      r_spike      <= {{(N_CH-1){1'b0}}, w_fire} << r_ptr;
      r_vout       <= w_vnew;
      r_vch        <= r_ptr;
      r_vvalid     <= 1'b1;
    end else begin
      r_spike  <= '0;
      r_vvalid <= 1'b0;
    end
  end

  assign spike   = r_spike;
  assign v_out   = r_vout;
  assign v_ch    = r_vch;
  assign v_valid = r_vvalid;

endmodule
